// File: rtl/store_lane_buffer.sv
// Store path from regfile to data RAM: lane alignment plus an in-order DEPTH-entry FIFO
// drained over a req/ack port. Optional macro MISALIGN_TRAP_EN drops misaligned stores and flags them.
module store_lane_buffer #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    st_valid,
  output logic                                    st_ready,
  input  logic [ADDR_BITS-1:0]                    st_addr,
  input  logic [DATA_BITS-1:0]                    st_data,
  input  logic [1:0]                              st_size,
  output logic                                    mem_req,
  input  logic                                    mem_ack,
  output logic [ADDR_BITS-$clog2(DATA_BITS/8)-1:0] mem_addr,
  output logic [DATA_BITS-1:0]                    mem_din,
  output logic [DATA_BITS/8-1:0]                  mem_sel,
  output logic                                    empty,
  output logic                                    misalign
);

  localparam int unsigned SEL_W = DATA_BITS / 8;
  localparam int unsigned OFF   = $clog2(SEL_W);
  localparam int unsigned WA_W  = ADDR_BITS - OFF;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [1:0]           w_size;
  logic [OFF-1:0]       w_lo_mask;
  logic [OFF-1:0]       w_lane;
  logic [SEL_W-1:0]     w_sel;
  logic [DATA_BITS-1:0] w_data_lo;
  logic [DATA_BITS-1:0] w_din;
  logic                 w_push;
  logic                 w_enq;
  logic                 w_pop;

  logic [WA_W-1:0]      r_addr_q [DEPTH];
  logic [DATA_BITS-1:0] r_din_q  [DEPTH];
  logic [SEL_W-1:0]     r_sel_q  [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  // Dword on a 32-bit RAM degrades to word.
  always_comb begin
    w_size = st_size;
    if (DATA_BITS == 32 && st_size == 2'b11) w_size = 2'b10;
  end

  // Lane select and lane-shifted data for the incoming store.
  always_comb begin
    w_lo_mask = '0;
    for (int i = 0; i < int'(OFF); i++) w_lo_mask[i] = (i < int'(w_size));
    w_lane = st_addr[OFF-1:0] & ~w_lo_mask;
    w_sel  = '0;
    w_data_lo = '0;
    for (int b = 0; b < int'(SEL_W); b++) begin
      w_sel[b] = (b >= int'(w_lane)) && (b < int'(w_lane) + (1 << int'(w_size)));
      if (b < (1 << int'(w_size))) w_data_lo[8*b +: 8] = st_data[8*b +: 8];
    end
    w_din = w_data_lo << {w_lane, 3'b000};
  end

  assign st_ready = (r_count < CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign mem_req  = !empty;
  assign w_push   = st_valid && st_ready;
  assign w_pop    = mem_req && mem_ack;

`ifdef MISALIGN_TRAP_EN
  logic w_mis;
  logic r_misalign;

  assign w_mis    = |(st_addr[OFF-1:0] & w_lo_mask);
  assign w_enq    = w_push && !w_mis;
  assign misalign = r_misalign;

  // Misaligned store is consumed but only reported, for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_push && w_mis;
  end
`else
  assign w_enq    = w_push;
  assign misalign = 1'b0;
`endif

  // Entry storage is intentionally not reset; validity comes from the count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_q[r_wr_ptr] <= st_addr[ADDR_BITS-1:OFF];
      r_din_q[r_wr_ptr]  <= w_din;
      r_sel_q[r_wr_ptr]  <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head payload is zeroed whenever there is no request.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_sel  = '0;
    if (mem_req) begin
      mem_addr = r_addr_q[r_rd_ptr];
      mem_din  = r_din_q[r_rd_ptr];
      mem_sel  = r_sel_q[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed bench for store_lane_buffer: 32-bit default instance plus a 64-bit instance for dword stores.
module tb_store_lane_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic        mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_sel;
  logic        empty;
  logic        misalign;

  logic        st_valid64;
  logic        st_ready64;
  logic [31:0] st_addr64;
  logic [63:0] st_data64;
  logic [1:0]  st_size64;
  logic        mem_req64;
  logic        mem_ack64;
  logic [28:0] mem_addr64;
  logic [63:0] mem_din64;
  logic [7:0]  mem_sel64;
  logic        empty64;
  logic        misalign64;

  int checks;
  int errors;

  store_lane_buffer #(.ADDR_BITS(32), .DATA_BITS(32), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_sel(mem_sel), .empty(empty), .misalign(misalign)
  );

  store_lane_buffer #(.ADDR_BITS(32), .DATA_BITS(64), .DEPTH(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid64), .st_ready(st_ready64),
    .st_addr(st_addr64), .st_data(st_data64), .st_size(st_size64),
    .mem_req(mem_req64), .mem_ack(mem_ack64), .mem_addr(mem_addr64),
    .mem_din(mem_din64), .mem_sel(mem_sel64), .empty(empty64), .misalign(misalign64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [29:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one store for exactly one clock edge.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [29:0] a, input logic [3:0] s,
                          input logic [31:0] d);
    chk({name, ".req"},  64'(mem_req),  64'(1'b1));
    chk({name, ".addr"}, 64'(mem_addr), 64'(a));
    chk({name, ".sel"},  64'(mem_sel),  64'(s));
    chk({name, ".din"},  64'(mem_din),  64'(d));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{32'h0000_1003, 32'h0000_00AB, 2'b00, 30'h400,        4'b1000, 32'hAB00_0000};
    vecs[1] = '{32'h0000_0006, 32'h1234_BEEF, 2'b01, 30'h1,          4'b1100, 32'hBEEF_0000};
    vecs[2] = '{32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 30'h4,          4'b1111, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0001, 32'hFFFF_FF5A, 2'b00, 30'h0,          4'b0010, 32'h0000_5A00};
    vecs[4] = '{32'h0000_0008, 32'h1122_3344, 2'b11, 30'h2,          4'b1111, 32'h1122_3344};
    vecs[5] = '{32'h0000_0000, 32'hCAFE_F00D, 2'b01, 30'h0,          4'b0011, 32'h0000_F00D};
    vecs[6] = '{32'hFFFF_FFFE, 32'h0000_0077, 2'b00, 30'h3FFF_FFFF,  4'b0100, 32'h0077_0000};

    rst_n = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
    st_valid64 = 1'b0; st_addr64 = '0; st_data64 = '0; st_size64 = '0; mem_ack64 = 1'b0;
    #12;
    chk("rst.req",      64'(mem_req),  64'(1'b0));
    chk("rst.empty",    64'(empty),    64'(1'b1));
    chk("rst.ready",    64'(st_ready), 64'(1'b1));
    chk("rst.misalign", 64'(misalign), 64'(1'b0));
    chk("rst.addr",     64'(mem_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-store lane alignment, then pop.
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].addr, vecs[i].data, vecs[i].size);
      chk_head($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_sel, vecs[i].exp_din);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk($sformatf("vec%0d.empty", i), 64'(empty), 64'(1'b1));
      chk($sformatf("vec%0d.zsel", i),  64'(mem_sel), 64'(0));
    end

    // Fill with no acks; fifth store held until one pop frees a slot.
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d.ready", k), 64'(st_ready), 64'(1'b1));
      push(32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 2'b10);
    end
    chk("full.ready", 64'(st_ready), 64'(1'b0));
    st_valid = 1'b1; st_addr = 32'h110; st_data = 32'hA000_0004; st_size = 2'b10;
    @(negedge clk);
    chk("full.ready2", 64'(st_ready), 64'(1'b0));
    chk_head("full.head", 30'h40, 4'b1111, 32'hA000_0000);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("afterpop.ready", 64'(st_ready), 64'(1'b1));
    chk_head("afterpop.head", 30'h41, 4'b1111, 32'hA000_0001);
    @(negedge clk);
    st_valid = 1'b0;
    chk("fifth.ready", 64'(st_ready), 64'(1'b0));
    mem_ack = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk_head($sformatf("drain%0d", k), 30'h40 + 30'(k), 4'b1111, 32'hA000_0000 + 32'(k));
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("drain.empty", 64'(empty), 64'(1'b1));

    // Push and pop together with two pending.
    push(32'h200, 32'hB000_0001, 2'b10);
    push(32'h204, 32'hB000_0002, 2'b10);
    st_valid = 1'b1; st_addr = 32'h208; st_data = 32'hB000_0003; st_size = 2'b10;
    mem_ack = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    chk("pp.empty", 64'(empty), 64'(1'b0));
    chk_head("pp.head1", 30'h81, 4'b1111, 32'hB000_0002);
    @(negedge clk);
    chk_head("pp.head2", 30'h82, 4'b1111, 32'hB000_0003);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pp.empty2", 64'(empty), 64'(1'b1));

    // Misaligned word store.
    push(32'h102, 32'h5566_7788, 2'b10);
`ifdef MISALIGN_TRAP_EN
    chk("mis.req",  64'(mem_req),  64'(1'b0));
    chk("mis.flag", 64'(misalign), 64'(1'b1));
    @(negedge clk);
    chk("mis.flag2", 64'(misalign), 64'(1'b0));
    chk("mis.empty", 64'(empty),    64'(1'b1));
`else
    chk_head("mis", 30'h40, 4'b1111, 32'h5566_7788);
    chk("mis.flag", 64'(misalign), 64'(1'b0));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mis.empty", 64'(empty), 64'(1'b1));
`endif

    // 64-bit RAM: dword and a single byte in an upper lane.
    st_valid64 = 1'b1; st_addr64 = 32'h8; st_data64 = 64'h0123_4567_89AB_CDEF; st_size64 = 2'b11;
    @(negedge clk);
    st_valid64 = 1'b0;
    chk("d64.req",  64'(mem_req64),  64'(1'b1));
    chk("d64.addr", 64'(mem_addr64), 64'(29'h1));
    chk("d64.sel",  64'(mem_sel64),  64'(8'hFF));
    chk("d64.din",  mem_din64,       64'h0123_4567_89AB_CDEF);
    mem_ack64 = 1'b1;
    @(negedge clk);
    st_valid64 = 1'b1; st_addr64 = 32'h5; st_data64 = 64'hFFFF_FFFF_FFFF_FFEE; st_size64 = 2'b00;
    mem_ack64 = 1'b0;
    @(negedge clk);
    st_valid64 = 1'b0;
    chk("b64.addr", 64'(mem_addr64), 64'(29'h0));
    chk("b64.sel",  64'(mem_sel64),  64'(8'b0010_0000));
    chk("b64.din",  mem_din64,       64'h0000_EE00_0000_0000);

    // Asynchronous reset with pending stores.
    push(32'h300, 32'h1, 2'b10);
    push(32'h304, 32'h2, 2'b10);
    push(32'h308, 32'h3, 2'b10);
    chk("ar.req_before", 64'(mem_req), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.req",   64'(mem_req),  64'(1'b0));
    chk("ar.empty", 64'(empty),    64'(1'b1));
    chk("ar.ready", 64'(st_ready), 64'(1'b1));
    chk("ar.req64", 64'(mem_req64), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ar.post%0d", k), 64'(mem_req), 64'(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
